// File: rtl/uart_rx_frame.sv
// 8N1 UART receiver: 16x oversampling, 2-of-3 majority vote, framing-error and break handling.
// RXD_VALID/FRAME_ERR pulse one CLK after the stop-bit mid-sample tick; no backpressure, consumer must take each byte.
module uart_rx_frame #(
  parameter int BAUD_DIV = 651
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       UART_RXD,
  output logic [7:0] RXD_DATA,
  output logic       RXD_VALID,
  output logic       FRAME_ERR,
  output logic       BUSY
);

  localparam logic [15:0] DIV_LAST = 16'(BAUD_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  logic        rx_m, rx_s;
  logic [15:0] div_cnt;
  logic        tick;

  state_t      state, state_d;
  logic [3:0]  s_cnt, s_cnt_d;
  logic [2:0]  bit_idx, bit_idx_d;
  logic [7:0]  shift, shift_d;
  logic        v7, v7_d, v8, v8_d;
  logic        vote;
  logic [7:0]  data_d;
  logic        valid_d, ferr_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= UART_RXD;
      rx_s <= rx_m;
    end
  end

  // Free-running: bit phase is recovered by s_cnt, not by realigning the divider.
  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      div_cnt <= 16'd0;
    end else if (tick) begin
      div_cnt <= 16'd0;
    end else begin
      div_cnt <= div_cnt + 16'd1;
    end
  end

  // Third sample is the live rx_s on the s_cnt=9 tick.
  assign vote = (v7 & v8) | (v7 & rx_s) | (v8 & rx_s);

  always_comb begin
    state_d   = state;
    s_cnt_d   = s_cnt;
    bit_idx_d = bit_idx;
    shift_d   = shift;
    v7_d      = v7;
    v8_d      = v8;
    data_d    = RXD_DATA;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;

    if (tick) begin
      if (state == S_START || state == S_DATA || state == S_STOP) begin
        s_cnt_d = s_cnt + 4'd1;
        if (s_cnt == 4'd7) v7_d = rx_s;
        if (s_cnt == 4'd8) v8_d = rx_s;
      end

      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            state_d = S_START;
            s_cnt_d = 4'd1;
          end
        end
        S_START: begin
          if (s_cnt == 4'd9 && vote) begin
            state_d = S_IDLE;
            s_cnt_d = 4'd0;
          end else if (s_cnt == 4'd15) begin
            state_d   = S_DATA;
            bit_idx_d = 3'd0;
          end
        end
        S_DATA: begin
          if (s_cnt == 4'd9) shift_d[bit_idx] = vote;
          if (s_cnt == 4'd15) begin
            if (bit_idx == 3'd7) state_d = S_STOP;
            else bit_idx_d = bit_idx + 3'd1;
          end
        end
        S_STOP: begin
          // Leave mid-stop-bit so a back-to-back start edge from a fast sender is not missed.
          if (s_cnt == 4'd9) begin
            s_cnt_d = 4'd0;
            if (vote) begin
              data_d  = shift;
              valid_d = 1'b1;
              state_d = S_IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = S_BREAK;
            end
          end
        end
        S_BREAK: begin
          if (rx_s) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= S_IDLE;
      s_cnt     <= 4'd0;
      bit_idx   <= 3'd0;
      shift     <= 8'd0;
      v7        <= 1'b0;
      v8        <= 1'b0;
      RXD_DATA  <= 8'd0;
      RXD_VALID <= 1'b0;
      FRAME_ERR <= 1'b0;
    end else begin
      state     <= state_d;
      s_cnt     <= s_cnt_d;
      bit_idx   <= bit_idx_d;
      shift     <= shift_d;
      v7        <= v7_d;
      v8        <= v8_d;
      RXD_DATA  <= data_d;
      RXD_VALID <= valid_d;
      FRAME_ERR <= ferr_d;
    end
  end

  assign BUSY = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: directed frame table, hand-written corner sequences, then random frames
// checked by a scoreboard of expected (byte / framing error) events with latency windows.
module tb_uart_rx_frame;

  localparam int B      = 8;
  localparam int NOM    = 16 * B;
  localparam int LAT_LO = 153 * B + 2;
  localparam int LAT_HI = 153 * B + B + 3;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       UART_RXD = 1'b1;
  logic [7:0] RXD_DATA;
  logic       RXD_VALID, FRAME_ERR, BUSY;

  uart_rx_frame #(.BAUD_DIV(B)) dut (
    .CLK(CLK), .RST(RST), .UART_RXD(UART_RXD),
    .RXD_DATA(RXD_DATA), .RXD_VALID(RXD_VALID), .FRAME_ERR(FRAME_ERR), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    bit         err;
    logic [7:0] dat;
    int         edge_cyc;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        e;
  bit         lax = 1'b0;
  int         pulse_cnt = 0;
  logic [7:0] model_last = 8'h00;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d want %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Scoreboard: every pulse must match the oldest outstanding expected event.
  always @(negedge CLK) begin
    if (!RST && (RXD_VALID || FRAME_ERR)) begin
      pulse_cnt++;
      chk("valid_err_exclusive", int'(RXD_VALID & FRAME_ERR), 0);
      if (!lax) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_kind_err", int'(FRAME_ERR), int'(e.err));
          chk("pulse_data", int'(RXD_DATA), int'(e.dat));
          chk_rng("pulse_latency", cyc - e.edge_cyc, LAT_LO, LAT_HI);
        end
      end
    end
  end

  task automatic drive_frame(input logic [7:0] b, input bit stop_ok, input int per);
    UART_RXD = 1'b0;
    repeat (per) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      UART_RXD = b[i];
      repeat (per) @(negedge CLK);
    end
    UART_RXD = stop_ok;
    repeat (per) @(negedge CLK);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int per,
                            input int hold, input int gap,
                            input bit exp_err, input logic [7:0] exp_dat);
    exp_q.push_back('{exp_err, exp_dat, cyc});
    drive_frame(b, stop_ok, per);
    if (!stop_ok) begin
      UART_RXD = 1'b0;
      repeat (hold) @(negedge CLK);
    end
    UART_RXD = 1'b1;
    repeat (gap) @(negedge CLK);
  endtask

  typedef struct {
    logic [7:0] dat;
    int         per;
    int         gap;
    logic [7:0] exp_dat;
  } vec_t;

  vec_t       vt[10];
  int         pc;
  bit         busy_seen;
  logic [7:0] rb;
  int         rper, rhold, rgap;
  bit         rok;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{8'h03, NOM, 2*NOM, 8'h03};
    vt[1] = '{8'hA5, NOM, 2*NOM, 8'hA5};
    vt[2] = '{8'h80, NOM, 2*NOM, 8'h80};
    vt[3] = '{8'h01, 124, 0,     8'h01};
    vt[4] = '{8'h02, 124, 0,     8'h02};
    vt[5] = '{8'h06, 124, 2*NOM, 8'h06};
    vt[6] = '{8'h01, 132, 0,     8'h01};
    vt[7] = '{8'h02, 132, 0,     8'h02};
    vt[8] = '{8'h06, 132, 2*NOM, 8'h06};
    vt[9] = '{8'h01, NOM, 2*NOM, 8'h01};

    // Reset held: outputs stay zero while the line toggles.
    @(negedge CLK);
    for (int i = 0; i < 12; i++) begin
      UART_RXD = (i % 2 == 0) ? 1'b0 : 1'b1;
      repeat (7) @(negedge CLK);
      chk("reset_outputs", int'({RXD_DATA, RXD_VALID, FRAME_ERR, BUSY}), 0);
    end
    UART_RXD = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    repeat (4 * B) @(negedge CLK);

    for (int r = 0; r < 10; r++) begin
      send_frame(vt[r].dat, 1'b1, vt[r].per, 0, vt[r].gap, 1'b0, vt[r].exp_dat);
      model_last = vt[r].dat;
      chk("row_data", int'(RXD_DATA), int'(vt[r].exp_dat));
      chk("row_queue_empty", exp_q.size(), 0);
    end

    // Framing error, break held three bit times, then recovery.
    pc = pulse_cnt;
    send_frame(8'h00, 1'b0, NOM, 3*NOM, 0, 1'b1, model_last);
    chk("break_busy_held", int'(BUSY), 1);
    chk("break_single_pulse", pulse_cnt, pc + 1);
    chk("break_queue_empty", exp_q.size(), 0);
    repeat (2 * B + 4) @(negedge CLK);
    chk("break_exit_idle", int'(BUSY), 0);
    repeat (NOM) @(negedge CLK);
    send_frame(8'h04, 1'b1, NOM, 0, 2*NOM, 1'b0, 8'h04);
    model_last = 8'h04;
    chk("after_break_data", int'(RXD_DATA), 4);

    // Glitch: 4-tick low pulse on an idle line.
    pc = pulse_cnt;
    busy_seen = 1'b0;
    UART_RXD = 1'b0;
    for (int i = 0; i < 4 * B; i++) begin
      @(negedge CLK);
      if (BUSY) busy_seen = 1'b1;
    end
    UART_RXD = 1'b1;
    for (int i = 0; i < 20 * B; i++) begin
      @(negedge CLK);
      if (BUSY) busy_seen = 1'b1;
    end
    chk("glitch_busy_seen", int'(busy_seen), 1);
    chk("glitch_busy_low", int'(BUSY), 0);
    chk("glitch_no_pulse", pulse_cnt, pc);
    chk("glitch_data_kept", int'(RXD_DATA), int'(model_last));

    // Reset in bit 4 of 0x55; the tail of that frame may decode as anything.
    lax = 1'b1;
    pc = pulse_cnt;
    fork
      drive_frame(8'h55, 1'b1, NOM);
      begin
        repeat (5 * NOM + NOM / 2) @(negedge CLK);
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        chk("midrst_data_zero", int'(RXD_DATA), 0);
        chk("midrst_busy_low", int'(BUSY), 0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
      end
    join
    UART_RXD = 1'b1;
    repeat (NOM) @(negedge CLK);
    chk("midrst_no_pulse", pulse_cnt, pc);
    repeat (10 * NOM) @(negedge CLK);
    lax = 1'b0;
    send_frame(8'h02, 1'b1, NOM, 0, 2*NOM, 1'b0, 8'h02);
    model_last = 8'h02;
    chk("midrst_next_data", int'(RXD_DATA), 2);

    // Random frames: rate within +-3 %, random gaps, occasional bad stop bit.
    for (int n = 0; n < 20; n++) begin
      rb    = 8'($urandom);
      rper  = $urandom_range(124, 132);
      rok   = ($urandom_range(0, 4) != 0);
      rhold = rok ? 0 : $urandom_range(0, 3) * rper;
      rgap  = rok ? ($urandom_range(0, 2) * rper + $urandom_range(0, 40))
                  : (rper + $urandom_range(0, 2) * rper);
      send_frame(rb, rok, rper, rhold, rgap, !rok, rok ? rb : model_last);
      if (rok) model_last = rb;
    end

    repeat (3 * NOM) @(negedge CLK);
    chk("final_queue_drained", exp_q.size(), 0);
    chk("final_data", int'(RXD_DATA), int'(model_last));
    chk("final_idle", int'(BUSY), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
